lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Hardware sequencer for the HD44780-compatible character LCD driven by the processor's `io_lcd_o` peripheral word. It runs the power-on initialisation sequence and then accepts command/data bytes over a valid/ready handshake. For each byte it generates the RS/EN/data timing and the post-command execution wait, so software no longer bit-bangs the LCD. Its `io_lcd_o` output uses the same 32-bit bit layout as the core's LCD register, so the two can be muxed at the top level.

## Interface
- `T_SETUP`, default 3: cycles RS/data are stable before EN rises (≥1).
- `T_EN`, default 25: EN high width in cycles (≥1).
- `T_HOLD`, default 3: cycles RS/data are held after EN falls (≥1).
- `T_CMD`, default 2000: execution wait for normal commands and data (≥1).
- `T_CLR`, default 80000: execution wait for clear/home (≥1).
- `T_PWRUP`, default 2000000: power-up wait before initialisation (≥1).
- Clock and reset: one clock, `clk_i`. Reset `rst_ni` is asynchronous and active-low.
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  controller can accept a request
- `req_rs_i`  in  1  0 = command, 1 = data
- `req_data_i`  in  8  byte to write
- `busy_o`  out  1  state ≠ IDLE
- `init_done_o`  out  1  initialisation complete (sticky until reset)
- `io_lcd_o`  out  32  bit 31 ON, bit 10 EN, bit 9 RS, bit 8 RW, bits [7:0] DATA, all other bits 0

## Operation
- FSM states and transitions:
  - PWRUP → INIT_LOAD → SETUP → PULSE → HOLD → WAIT.
  - WAIT → INIT_LOAD while init commands remain.
  - WAIT → IDLE after the last init command and after every request.
  - IDLE → SETUP on handshake.
- Init sequence, RS = 0, in this order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry mode). A 2-bit index selects the command.
- Handshake rules:
  - `req_ready_o` = 1 only in IDLE.
  - A transfer occurs when `req_valid_i & req_ready_o` on a rising edge; RS and data are latched on that edge.
  - Requests are never accepted during init. A held `req_valid_i` waits.
- Per-phase `io_lcd_o` content:
  - ON = 1 in every state after reset.
  - EN = 1 only in PULSE.
  - RW is always 0; the block is write-only and does not poll the busy flag.
  - RS/DATA hold the latched byte through SETUP, PULSE and HOLD. They keep their last value in WAIT and IDLE.
- Wait selection: T_CLR when RS = 0 and data ∈ {0x01, 0x02, 0x03}; T_CMD otherwise.
- Counter:
  - A single down-counter of width `$clog2(max(all params)+1)`.
  - It is loaded with the phase length minus 1 on phase entry; the phase ends at 0.
  - No wrap-around is permitted.
- `init_done_o` sets on the first entry to IDLE and stays set until reset.
- Reset at any time, including mid-PULSE: all outputs take their reset values asynchronously, EN drops immediately, and the full power-up and init sequence restarts on release.

## Timing
- Reset values: `io_lcd_o` = 0x0000_0000, `req_ready_o` = 0, `busy_o` = 1, `init_done_o` = 0.
- From the first clock edge after reset release, `io_lcd_o` = 0x8000_0000 for T_PWRUP cycles.
- All outputs are registered, with their values computed from the next state. Outputs are glitch-free.
- Accept in cycle k; the phases then run as follows:
  - SETUP occupies cycles k+1 … k+T_SETUP.
  - PULSE occupies the next T_EN cycles.
  - HOLD occupies the next T_HOLD cycles.
  - WAIT occupies the next T_wait cycles.
  - `req_ready_o` reasserts in cycle k+1+T_SETUP+T_EN+T_HOLD+T_wait.
- Back-to-back requests incur no extra idle cycles beyond the single IDLE acceptance cycle.
- Init latency from reset release to `init_done_o`: T_PWRUP + 4·(T_SETUP+T_EN+T_HOLD) + 3·T_CMD + T_CLR (+1 for the INIT_LOAD cycle per command).

## Structure
- Package `lcd_ctrl_pkg` contains:
  - the state enum;
  - bit-position constants `LCD_ON_BIT`=31, `LCD_EN_BIT`=10, `LCD_RS_BIT`=9, `LCD_RW_BIT`=8;
  - the init command ROM as a localparam array;
  - the long-command predicate function.
- The design is flat with no sub-module; the counter and FSM live in `lcd_ctrl`.

## Test plan
All scenarios use bench parameters T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLR=20, T_PWRUP=10.
1. **Reset release.** `io_lcd_o` = 0x8000_0000 for 10 cycles. Then four EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS = 0, and the third is followed by a 20-cycle wait. `init_done_o` and `req_ready_o` rise 77 cycles after release.
2. **Data write, RS=1, 0x41.** `io_lcd_o` = 0x8000_0241 for 2 cycles, then 0x8000_0641 for 3 cycles, then 0x8000_0241 for 2 cycles. Ready reasserts 12 cycles after accept.
3. **Clear command, RS=0, 0x01.** Ready reasserts 27 cycles after accept. **Command 0x80.** Ready reasserts after 12 cycles.
4. **Valid held high with two queued bytes, 0x48 then 0x49.** Each byte is accepted in the first IDLE cycle. The EN pulses are exactly 13 cycles apart rising-edge to rising-edge.
5. **`req_valid_i` high from reset.** No acceptance before `init_done_o`. Acceptance occurs in the first IDLE cycle.
6. **`rst_ni` low during PULSE.** `io_lcd_o` = 0 and `init_done_o` = 0 with no clock edge. After release, scenario 1 repeats exactly.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types and constants for the character LCD sequencer
package lcd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } lcd_state_e;

   localparam int LCD_ON_BIT = 31;
   localparam int LCD_EN_BIT = 10;
   localparam int LCD_RS_BIT = 9;
   localparam int LCD_RW_BIT = 8;

   // Entry 0 is issued first: function set, display on, clear, entry mode.
   localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

   // Clear and return-home commands need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 init/write sequencer producing the io_lcd_o peripheral word
module lcd_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int T_SETUP = 3,
   parameter int T_EN    = 25,
   parameter int T_HOLD  = 3,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 80000,
   parameter int T_PWRUP = 2000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_rs_i,
   input  logic [7:0]  req_data_i,
   output logic        busy_o,
   output logic        init_done_o,
   output logic [31:0] io_lcd_o
);

   localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN), max_int(T_HOLD, T_CMD)),
                                  max_int(T_CLR, T_PWRUP));
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);
   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);

   lcd_state_e       state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [1:0]       idx_q, idx_n;
   logic             rs_q, rs_n;
   logic [7:0]       data_q, data_n;
   logic [31:0]      lcd_n;
   logic             ready_n, busy_n, done_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_PWRUP;
         cnt_q   <= LD_PWRUP;
         idx_q   <= 2'd0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         rs_q    <= rs_n;
         data_q  <= data_n;
      end
   end

   // Each timed phase counts down from its length minus one and exits on zero.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      rs_n    = rs_q;
      data_n  = data_q;
      unique case (state_q)
         ST_PWRUP: begin
            if (cnt_q == '0) state_n = ST_INIT_LOAD;
            else             cnt_n   = cnt_q - CNT_W'(1);
         end
         ST_INIT_LOAD: begin
            rs_n    = 1'b0;
            data_n  = INIT_ROM[idx_q];
            state_n = ST_SETUP;
            cnt_n   = LD_SETUP;
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_n = ST_PULSE;
               cnt_n   = LD_EN;
            end else cnt_n = cnt_q - CNT_W'(1);
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_n = ST_HOLD;
               cnt_n   = LD_HOLD;
            end else cnt_n = cnt_q - CNT_W'(1);
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_n = ST_WAIT;
               cnt_n   = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
            end else cnt_n = cnt_q - CNT_W'(1);
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (!init_done_o && idx_q != 2'd3) begin
                  idx_n   = idx_q + 2'd1;
                  state_n = ST_INIT_LOAD;
               end else state_n = ST_IDLE;
            end else cnt_n = cnt_q - CNT_W'(1);
         end
         ST_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               rs_n    = req_rs_i;
               data_n  = req_data_i;
               state_n = ST_SETUP;
               cnt_n   = LD_SETUP;
            end
         end
         default: begin
            state_n = ST_PWRUP;
            cnt_n   = LD_PWRUP;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with it.
   always_comb begin
      lcd_n             = 32'h0;
      lcd_n[LCD_ON_BIT] = 1'b1;
      lcd_n[LCD_EN_BIT] = (state_n == ST_PULSE);
      lcd_n[LCD_RS_BIT] = rs_n;
      lcd_n[LCD_RW_BIT] = 1'b0;
      lcd_n[7:0]        = data_n;
      ready_n           = (state_n == ST_IDLE);
      busy_n            = !ready_n;
      done_n            = init_done_o | ready_n;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         io_lcd_o    <= 32'h0;
         req_ready_o <= 1'b0;
         busy_o      <= 1'b1;
         init_done_o <= 1'b0;
      end else begin
         io_lcd_o    <= lcd_n;
         req_ready_o <= ready_n;
         busy_o      <= busy_n;
         init_done_o <= done_n;
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl with a schedule-based reference model
module tb_lcd_ctrl;

   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 2;
   localparam int T_CMD   = 5;
   localparam int T_CLR   = 20;
   localparam int T_PWRUP = 10;
   localparam int PH      = T_SETUP + T_EN + T_HOLD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_rs_i;
   logic [7:0]  req_data_i;
   logic        busy_o;
   logic        init_done_o;
   logic [31:0] io_lcd_o;

   int checks = 0;
   int errors = 0;

   lcd_ctrl #(
      .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
      .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWRUP(T_PWRUP)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_rs_i(req_rs_i),
      .req_data_i(req_data_i),
      .busy_o(busy_o),
      .init_done_o(init_done_o),
      .io_lcd_o(io_lcd_o)
   );

   always #5 clk = ~clk;

   // Reference model: every byte is a window of edges starting at its SETUP entry.
   logic [7:0]  rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
   int          n, e_start, e_free, init_end;
   int          init_s [4];
   logic        sh_rs;
   logic [7:0]  sh_data;
   logic [31:0] ex_io;
   logic        ex_ready, ex_busy, ex_done;
   int          en_rise [$];

   function automatic int wt(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_CMD;
   endfunction

   task automatic model_reset();
      int t;
      n = 0; e_start = -1000; e_free = 1 << 30;
      sh_rs = 1'b0; sh_data = 8'h00;
      ex_io = 32'h0; ex_ready = 1'b0; ex_busy = 1'b1; ex_done = 1'b0;
      t = T_PWRUP;
      for (int i = 0; i < 4; i++) begin
         init_s[i] = t + 1;
         t = init_s[i] + PH + wt(1'b0, rom[i]);
      end
      init_end = t;
   endtask

   task automatic model_step();
      logic en;
      n++;
      if (ex_ready && req_valid_i) begin
         sh_rs = req_rs_i; sh_data = req_data_i;
         e_start = n; e_free = n + PH + wt(req_rs_i, req_data_i);
      end
      for (int i = 0; i < 4; i++)
         if (n == init_s[i]) begin
            sh_rs = 1'b0; sh_data = rom[i];
            e_start = n; e_free = n + PH + wt(1'b0, rom[i]);
         end
      ex_done  = (n >= init_end);
      ex_ready = ex_done && (n >= e_free);
      ex_busy  = !ex_ready;
      en       = (n >= e_start + T_SETUP) && (n < e_start + T_SETUP + T_EN);
      ex_io    = 32'h8000_0000 | {21'b0, en, sh_rs, 1'b0, sh_data};
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, n, got, want);
      end
   endtask

   initial begin
      logic prev_en = 1'b0;
      forever begin
         @(negedge clk);
         chk("io_lcd", io_lcd_o, ex_io);
         chk("ready", {31'b0, req_ready_o}, {31'b0, ex_ready});
         chk("busy", {31'b0, busy_o}, {31'b0, ex_busy});
         chk("init_done", {31'b0, init_done_o}, {31'b0, ex_done});
         if (io_lcd_o[10] && !prev_en) en_rise.push_back(n);
         prev_en = io_lcd_o[10];
      end
   end

   task automatic wait_n(input int target);
      int g = 0;
      while (n < target && g < 2000) begin @(negedge clk); g++; end
      if (n < target) chk("wait_edge_timeout", n, target);
   endtask

   task automatic send(input logic rs, input logic [7:0] d, output int acc);
      int g = 0;
      req_valid_i = 1'b1; req_rs_i = rs; req_data_i = d;
      while (!req_ready_o && g < 1000) begin @(negedge clk); g++; end
      if (!req_ready_o) chk("accept_timeout", {31'b0, req_ready_o}, 32'd1);
      acc = n + 1;
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input int e0, output int lat);
      int g = 0;
      while (!req_ready_o && g < 1000) begin @(negedge clk); g++; end
      if (!req_ready_o) chk("ready_timeout", {31'b0, req_ready_o}, 32'd1);
      lat = n - e0;
   endtask

   task automatic check_init();
      int g = 0;
      while (!init_done_o && g < 300) begin
         @(negedge clk); g++;
         if (n == 5)  chk("pwrup_io", io_lcd_o, 32'h8000_0000);
         if (n == 13) chk("init_pulse0_io", io_lcd_o, 32'h8000_0438);
         if (n == 50) chk("clear_wait_io", io_lcd_o, 32'h8000_0001);
         if (n == 76) chk("init_done_early", {31'b0, init_done_o}, 32'd0);
      end
      chk("init_done_edge", n, 32'd77);
      chk("ready_at_init", {31'b0, req_ready_o}, 32'd1);
   endtask

   initial begin
      int e, e2, lat, gap;
      logic [7:0] d;
      logic rs;
      rst_n = 1'b0; req_valid_i = 1'b0; req_rs_i = 1'b0; req_data_i = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_io", io_lcd_o, 32'h0);
      chk("reset_busy", {31'b0, busy_o}, 32'd1);
      rst_n = 1'b1;
      check_init();

      send(1'b1, 8'h41, e);
      chk("data_setup_io", io_lcd_o, 32'h8000_0241);
      wait_n(e + 2);
      chk("data_pulse_io", io_lcd_o, 32'h8000_0641);
      wait_n(e + 5);
      chk("data_hold_io", io_lcd_o, 32'h8000_0241);
      wait_ready(e, lat);
      chk("data_ready_lat", lat, 32'd12);

      send(1'b0, 8'h01, e);
      wait_ready(e, lat);
      chk("clear_ready_lat", lat, 32'd27);
      send(1'b0, 8'h80, e);
      wait_ready(e, lat);
      chk("cmd80_ready_lat", lat, 32'd12);

      en_rise.delete();
      send(1'b1, 8'h48, e);
      send(1'b1, 8'h49, e2);
      chk("b2b_accept_gap", e2 - e, 32'd13);
      wait_ready(e2, lat);
      chk("b2b_pulses", en_rise.size(), 32'd2);
      if (en_rise.size() >= 2) chk("b2b_en_spacing", en_rise[1] - en_rise[0], 32'd13);

      for (int i = 0; i < 30; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         rs = 1'($urandom_range(0, 1));
         d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         send(rs, d, e);
      end
      wait_ready(e, lat);

      rst_n = 1'b0; req_valid_i = 1'b1; req_rs_i = 1'b1; req_data_i = 8'h5A;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(1'b1, 8'h5A, e);
      chk("held_valid_accept_edge", e, 32'd78);
      wait_n(e + 3);
      chk("pulse_before_reset", io_lcd_o, 32'h8000_065A);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_io", io_lcd_o, 32'h0);
      chk("async_reset_done", {31'b0, init_done_o}, 32'd0);
      chk("async_reset_ready", {31'b0, req_ready_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_init();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
